// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register with stall/bubble hazard control and a registered occupancy count.
// Define PIPE_SKID_EN to add a skid entry, which removes the out_ready -> in_ready path.
module pipe_reg_elastic #(
   parameter int                 WIDTH       = 32,
   parameter logic [WIDTH-1:0]   DEFAULT_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             stall,
   input  logic             bubble,
   output logic [1:0]       occupancy
);

   // Handshake: a payload moves on any cycle where valid & ready are both high on that side;
   // the sender holds valid and data stable until that cycle.
   logic             in_xfer;
   logic             out_xfer;
   logic             main_valid, main_valid_d;
   logic [WIDTH-1:0] main_data,  main_data_d;
   logic [1:0]       occ_q, occ_d;

`ifdef PIPE_SKID_EN
   logic             skid_valid, skid_valid_d;
   logic [WIDTH-1:0] skid_data,  skid_data_d;

   assign in_ready = ~skid_valid & ~stall & ~bubble & ~rst;
`else
   assign in_ready = (~main_valid | out_ready) & ~stall & ~bubble & ~rst;
`endif

   assign out_valid = main_valid & ~stall;
   assign out_data  = main_data;
   assign occupancy = occ_q;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   always_comb begin
      main_valid_d = main_valid;
      main_data_d  = main_data;
`ifdef PIPE_SKID_EN
      skid_valid_d = skid_valid;
      skid_data_d  = skid_data;
`endif
      if (bubble) begin
         main_valid_d = 1'b0;
         main_data_d  = DEFAULT_VAL;
`ifdef PIPE_SKID_EN
         skid_valid_d = 1'b0;
         skid_data_d  = DEFAULT_VAL;
`endif
      end else if (!stall) begin
         if (out_xfer) begin
            // The skid entry is always older than any new input, so it drains first.
`ifdef PIPE_SKID_EN
            if (skid_valid) begin
               main_valid_d = 1'b1;
               main_data_d  = skid_data;
               skid_valid_d = 1'b0;
               skid_data_d  = DEFAULT_VAL;
            end else
`endif
            if (in_xfer) begin
               main_valid_d = 1'b1;
               main_data_d  = in_data;
            end else begin
               main_valid_d = 1'b0;
               main_data_d  = DEFAULT_VAL;
            end
         end else if (in_xfer) begin
`ifdef PIPE_SKID_EN
            if (main_valid) begin
               skid_valid_d = 1'b1;
               skid_data_d  = in_data;
            end else
`endif
            begin
               main_valid_d = 1'b1;
               main_data_d  = in_data;
            end
         end
      end
`ifdef PIPE_SKID_EN
      occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
`else
      occ_d = {1'b0, main_valid_d};
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_data  <= DEFAULT_VAL;
         occ_q      <= 2'd0;
`ifdef PIPE_SKID_EN
         skid_valid <= 1'b0;
         skid_data  <= DEFAULT_VAL;
`endif
      end else begin
         main_valid <= main_valid_d;
         main_data  <= main_data_d;
         occ_q      <= occ_d;
`ifdef PIPE_SKID_EN
         skid_valid <= skid_valid_d;
         skid_data  <= skid_data_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: table of per-cycle vectors plus hand sequences for backpressure,
// bubble and reset; payload order is tracked through an expected queue.
module tb_pipe_reg_elastic;

   localparam int         W   = 8;
   localparam logic [W-1:0] DEF = 8'hEE;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         stall;
   logic         bubble;
   logic [1:0]   occupancy;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic         iv;
      logic [W-1:0] d;
      logic         ordy;
      logic         st;
      logic         bu;
      logic         e_ov;
      logic [W-1:0] e_od;
      logic         e_ir;
      logic [1:0]   e_occ;
   } vec_t;

   vec_t tbl[22];

   pipe_reg_elastic #(.WIDTH(W), .DEFAULT_VAL(DEF)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .stall     (stall),
      .bubble    (bubble),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Inputs are applied just after a rising edge; outputs and handshakes are sampled at the falling edge.
   task automatic cyc(input logic r, input logic iv, input logic [W-1:0] d, input logic ordy,
                      input logic st, input logic bu, input logic e_ov, input logic [W-1:0] e_od,
                      input logic e_ir, input logic [1:0] e_occ, input string nm);
      rst = r; in_valid = iv; in_data = d; out_ready = ordy; stall = st; bubble = bu;
      @(negedge clk);
      chk({nm, "_out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
      chk({nm, "_out_data"},  {24'd0, out_data},  {24'd0, e_od});
      chk({nm, "_in_ready"},  {31'd0, in_ready},  {31'd0, e_ir});
      chk({nm, "_occupancy"}, {30'd0, occupancy}, {30'd0, e_occ});
      if (r || bu) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL %s_sb_extra actual=%0h required=none", nm, out_data);
            end else begin
               chk({nm, "_sb_order"}, {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
         end
         if (in_valid && in_ready) exp_q.push_back(in_data);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; bubble = 1'b0;

      //               iv  d      or  st  bu  ov  od     ir  occ
      tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0};
      tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1};
      tbl[2]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0};
      for (int i = 3; i <= 9; i++)
         tbl[i] = '{1'b1, 8'(i - 1), 1'b1, 1'b0, 1'b0, 1'b1, 8'(i - 2), 1'b1, 2'd1};
      tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 2'd1};
      tbl[11] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0};
      tbl[12] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 2'd1};
      tbl[13] = tbl[12];
      tbl[14] = tbl[12];
      tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 2'd1};
      tbl[16] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0};
      tbl[17] = '{1'b1, 8'h78, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 2'd1};
      tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0};
      tbl[19] = '{1'b1, 8'h90, 1'b1, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0};
      tbl[20] = '{1'b1, 8'h91, 1'b0, 1'b0, 1'b1, 1'b1, 8'h90, 1'b0, 2'd1};
      tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0};

      @(posedge clk);
      #1;
      cyc(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, DEF, 1'b0, 2'd0, "reset");

      for (int i = 0; i < 22; i++)
         cyc(1'b0, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].st, tbl[i].bu,
             tbl[i].e_ov, tbl[i].e_od, tbl[i].e_ir, tbl[i].e_occ, $sformatf("row%0d", i));

`ifdef PIPE_SKID_EN
      cyc(1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0, "skid0");
      cyc(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 2'd1, "skid1");
      cyc(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 2'd2, "skid2");
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 2'd2, "skid3");
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd1, "skid4");
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0, "skid5");
      cyc(1'b0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0, "bs0");
      cyc(1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB0, 1'b1, 2'd1, "bs1");
      cyc(1'b0, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 1'b0, 8'hB0, 1'b0, 2'd2, "bs2");
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0, "bs3");
      cyc(1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0, "rs0");
      cyc(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b1, 2'd1, "rs1");
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b0, 2'd2, "rs2");
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0, "rs3");
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0, "rs4");
`else
      cyc(1'b0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0, "bp0");
      cyc(1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB0, 1'b0, 2'd1, "bp1");
      cyc(1'b0, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB0, 1'b1, 2'd1, "bp2");
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0, 2'd1, "bp3");
      cyc(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0, 2'd1, "rs0");
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0, "rs1");
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, DEF,   1'b1, 2'd0, "rs2");
`endif

      chk("sb_drain", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
